// File: rtl/alu_issue.sv
// Issue front end for the RV32I integer ALU: decodes one instruction into registered
// ALU controls, captures the ALU result, and presents writeback/branch outcome.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    input  logic [31:0] alu_result,
    input  logic        zero_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [31:0] rd_data,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD              = 4'b0000,
        ALU_SUB              = 4'b0001,
        ALU_AND              = 4'b0010,
        ALU_OR               = 4'b0011,
        ALU_XOR              = 4'b0100,
        ALU_SHIFTL           = 4'b0101,
        ALU_SHIFTR           = 4'b0110,
        ALU_SHIFTR_ARITH     = 4'b0111,
        ALU_LESS_THAN        = 4'b1000,
        ALU_LESS_THAN_SIGNED = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_e      state_q, state_d;
    logic        accept, capture;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        is_r;
    logic [31:0] imm_i, imm_b;
    logic        unused_rs1_field;

    alu_op_e     dec_ctrl;
    logic [31:0] dec_inp1, dec_inp2, dec_tgt;
    logic        dec_ill, dec_wr, dec_br;

    alu_op_e     alu_ctrl_q;
    logic [31:0] inp1_q, inp2_q;
    logic [4:0]  p_rd_q;
    logic        p_wr_q, p_br_q, p_ill_q;
    logic [2:0]  p_f3_q;
    logic [31:0] p_tgt_q;

    logic [4:0]  rd_addr_q;
    logic        rd_we_q, taken_q, ill_q;
    logic [31:0] rd_data_q, tgt_q;
    logic        br_cond;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign is_r             = (opcode == OPC_R);
    assign imm_i            = {{20{instr[31]}}, instr[31:20]};
    assign imm_b            = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_inp1 = '0;
        dec_inp2 = '0;
        dec_tgt  = '0;
        dec_ill  = 1'b1;
        dec_wr   = 1'b0;
        dec_br   = 1'b0;
        case (opcode)
            OPC_R, OPC_I: begin
                dec_ill  = 1'b0;
                dec_wr   = 1'b1;
                dec_inp1 = rs1_data;
                dec_inp2 = is_r ? rs2_data : imm_i;
                // funct7 only constrains I-type on shifts, where instr[31:25] overlays it
                case (funct3)
                    3'b000: begin
                        if (is_r && funct7 == F7_ALT)       dec_ctrl = ALU_SUB;
                        else if (is_r && funct7 != F7_ZERO) dec_ill  = 1'b1;
                    end
                    3'b001: begin
                        dec_ctrl = ALU_SHIFTL;
                        if (funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                    3'b010: begin
                        dec_ctrl = ALU_LESS_THAN_SIGNED;
                        if (is_r && funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                    3'b011: begin
                        dec_ctrl = ALU_LESS_THAN;
                        if (is_r && funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                    3'b100: begin
                        dec_ctrl = ALU_XOR;
                        if (is_r && funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec_ctrl = ALU_SHIFTR;
                        else if (funct7 == F7_ALT) dec_ctrl = ALU_SHIFTR_ARITH;
                        else                       dec_ill  = 1'b1;
                    end
                    3'b110: begin
                        dec_ctrl = ALU_OR;
                        if (is_r && funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                    default: begin
                        dec_ctrl = ALU_AND;
                        if (is_r && funct7 != F7_ZERO) dec_ill = 1'b1;
                    end
                endcase
                if (!is_r && funct3[1:0] == 2'b01) dec_inp2 = {27'b0, instr[24:20]};
            end
            OPC_B: begin
                dec_ill  = 1'b0;
                dec_br   = 1'b1;
                dec_inp1 = rs1_data;
                dec_inp2 = rs2_data;
                dec_tgt  = pc + imm_b;
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec_ctrl = ALU_LESS_THAN_SIGNED;
                    3'b110, 3'b111: dec_ctrl = ALU_LESS_THAN;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            default: ;
        endcase
        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_inp1 = '0;
            dec_inp2 = '0;
            dec_tgt  = '0;
            dec_wr   = 1'b0;
            dec_br   = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        in_ready  = (state_q == S_IDLE) & ~rst;
        out_valid = (state_q == S_DONE);
        case (state_q)
            S_IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                capture = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // funct3[2] picks result-based compare over the zero flag; funct3[0] inverts the sense
    assign br_cond = (p_f3_q[2] ? (alu_result != '0) : zero_flag) ^ p_f3_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ctrl_q <= ALU_ADD;
            inp1_q     <= '0;
            inp2_q     <= '0;
            p_rd_q     <= '0;
            p_wr_q     <= 1'b0;
            p_br_q     <= 1'b0;
            p_ill_q    <= 1'b0;
            p_f3_q     <= '0;
            p_tgt_q    <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            rd_data_q  <= '0;
            taken_q    <= 1'b0;
            tgt_q      <= '0;
            ill_q      <= 1'b0;
        end else begin
            if (accept) begin
                alu_ctrl_q <= dec_ctrl;
                inp1_q     <= dec_inp1;
                inp2_q     <= dec_inp2;
                p_rd_q     <= dec_wr ? instr[11:7] : 5'd0;
                p_wr_q     <= dec_wr;
                p_br_q     <= dec_br;
                p_ill_q    <= dec_ill;
                p_f3_q     <= funct3;
                p_tgt_q    <= dec_tgt;
            end
            if (capture) begin
                rd_addr_q <= p_rd_q;
                rd_we_q   <= p_wr_q && (p_rd_q != 5'd0);
                rd_data_q <= p_wr_q ? alu_result : '0;
                taken_q   <= p_br_q && br_cond;
                tgt_q     <= p_tgt_q;
                ill_q     <= p_ill_q;
            end
        end
    end

    assign alu_control   = alu_ctrl_q;
    assign alu_inp1      = inp1_q;
    assign alu_inp2      = inp2_q;
    assign rd_addr       = rd_addr_q;
    assign rd_we         = rd_we_q;
    assign rd_data       = rd_data_q;
    assign branch_taken  = taken_q;
    assign branch_target = tgt_q;
    assign illegal       = ill_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue-side front end for the ALU. Accepts one RV32I integer instruction with its register operands through a valid/ready handshake and decodes it into `alu_control`, `alu_inp1` and `alu_inp2`, holding them stable for the combinational ALU. It then captures `alu_result`/`zero_flag` and presents a writeback or branch decision through a second valid/ready handshake. It sits between the register-file read stage and writeback/PC update.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `in_valid`  in  1  instruction/operands valid
- `in_ready`  out  1  block can accept
- `instr`  in  32  instruction word
- `rs1_data`, `rs2_data`  in  32 each  register operands
- `pc`  in  32  instruction address
- `alu_control`  out  4  registered ALU opcode
- `alu_inp1`, `alu_inp2`  out  32 each  registered ALU operands
- `alu_result`  in  32  ALU result
- `zero_flag`  in  1  ALU zero flag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts
- `rd_addr`  out  5  destination register
- `rd_we`  out  1  register write enable
- `rd_data`  out  32  writeback data
- `branch_taken`  out  1  conditional branch taken
- `branch_target`  out  32  pc + B-immediate
- `illegal`  out  1  unsupported encoding

## Operation
- ALU codes (alu_defs): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SHIFTL 0101, SHIFTR 0110, SHIFTR_ARITH 0111, LESS_THAN 1000, LESS_THAN_SIGNED 1001.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, decode, register ALU outputs, go to EXEC.
  - EXEC: ALU outputs are held. Capture `alu_result` and `zero_flag` into the output registers, go to DONE.
  - DONE: `out_valid`=1, all outputs held. On `out_ready`, go to IDLE.
- R-type (opcode 0110011): `inp1`=rs1, `inp2`=rs2. funct3/funct7 decode:
  - 000/0000000 ADD; 000/0100000 SUB
  - 001/0 SHIFTL
  - 010 LESS_THAN_SIGNED; 011 LESS_THAN
  - 100 XOR
  - 101/0 SHIFTR; 101/0100000 SHIFTR_ARITH
  - 110 OR; 111 AND
  - Any other funct7 is illegal.
- I-type (opcode 0010011): `inp2` = sign-extended instr[31:20]. Same funct3 map, with no SUB.
  - Shifts use `inp2` = {27'b0, instr[24:20]}; instr[31:25] must be 0 or 0100000, else illegal.
- R/I-type results: `rd_data`=`alu_result`; `rd_we`=1 when `rd`≠0.
- Branch (opcode 1100011): `inp1`=rs1, `inp2`=rs2, `rd_we`=0.
  - BEQ/BNE use SUB; taken = `zero_flag` / ~`zero_flag`.
  - BLT/BGE use LESS_THAN_SIGNED; BLTU/BGEU use LESS_THAN. Taken = result≠0 (LT) or result==0 (GE).
  - funct3 010/011 is illegal.
  - `branch_target` = pc + sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}, modulo 2^32.
- Non-branch instructions: `branch_taken`=0 and `branch_target`=0.
- Illegal instructions still traverse EXEC/DONE with `alu_control`=ADD, both operands 0, `illegal`=1, `rd_we`=0, `branch_taken`=0.

## Timing
- Reset values:
  - State IDLE.
  - `alu_control`=0000, both operands 0.
  - `out_valid`, `rd_addr`, `rd_we`, `rd_data`, `branch_taken`, `branch_target`, `illegal` all 0.
  - `in_ready`=0 while `rst` is high.
- `in_ready` = (state==IDLE) & ~rst. It is combinational from state only and does not depend on `in_valid`.
- Handshake acceptance at edge k:
  - ALU outputs valid after edge k.
  - Results captured at edge k+1.
  - `out_valid` high after edge k+1.
  - Earliest next acceptance at edge k+3, given `out_ready`=1 at edge k+2.
- `alu_*` outputs hold their last value through DONE and IDLE until the next acceptance.
- While `out_valid`=1 and `out_ready`=0, every output is stable and no input is accepted.
- `rst` asserted in any state:
  - `out_valid` and `in_ready` drop immediately (asynchronous).
  - The in-flight instruction is discarded.
  - The block resumes in IDLE on the first edge after deassertion.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Test plan
The bench models the ALU as an ideal combinational RV32I responder.
- ADD x3,x1,x2 (`instr`=0x002081B3), rs1=5, rs2=7, accepted at edge k → `alu_control`=0000, `inp1`=5, `inp2`=7. After edge k+1: `out_valid`=1, `rd_addr`=3, `rd_we`=1, `rd_data`=12.
- ADDI x5,x0,-1 (0xFFF00293), rs1=0 → `inp2`=0xFFFFFFFF, `rd_data`=0xFFFFFFFF, `rd_we`=1. Repeat with rd=0 → `rd_we`=0.
- BEQ x1,x2,+8 (0x00208463), pc=0x100, rs1=rs2=9 → `alu_control`=0001, `branch_taken`=1, `branch_target`=0x108, `rd_we`=0. With rs2=8 → `branch_taken`=0.
- SRAI x4,x1,1 (0x4010D213), rs1=0x80000000 → `alu_control`=0111, `inp2`=1, `rd_data`=0xC0000000. Instruction 0x00000000 → `illegal`=1, `rd_we`=0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles in DONE with `in_valid`=1 and a new instruction → outputs constant, `in_ready`=0, new instruction not accepted.
  - Then `out_ready`=1 → IDLE, new instruction accepted on the following edge.
- Assert `rst` during EXEC → `out_valid`=0 and all outputs at reset values immediately. After deassertion, the next instruction completes normally.
